// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (also used by the receiver),
// parity mode and frame-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    UART_IDLE   = 3'd0,
    UART_START  = 3'd1,
    UART_DATA   = 3'd2,
    UART_PARITY = 3'd3,
    UART_STOP   = 3'd4
  } uart_state_e;

  // Seed XORed into the data parity; 0 gives even parity over data+parity.
  localparam logic PARITY_SEED = 1'b0;

  function automatic int frame_cycles(input int clks_per_bit, input int data_bits,
                                      input int parity_en);
    return (2 + data_bits + parity_en) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles while run is high and pulses
// bit_done on the last cycle of each period.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_done = run && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!run || bit_done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one word per valid/ready handshake, framed as start,
// LSB-first data, optional even parity and one stop bit on a registered line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 tx_out,
  output logic                 busy
);

  localparam int BIT_CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 bit_done;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (state_q != UART_IDLE),
    .bit_done(bit_done)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    unique case (state_q)
      UART_IDLE: begin
        if (in_valid) begin
          shift_d   = in_data;
          parity_d  = PARITY_SEED ^ (^in_data);
          bit_cnt_d = '0;
          state_d   = UART_START;
        end
      end
      UART_START: begin
        if (bit_done) state_d = UART_DATA;
      end
      UART_DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = PARITY_EN ? UART_PARITY : UART_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      UART_PARITY: begin
        if (bit_done) state_d = UART_STOP;
      end
      UART_STOP: begin
        if (bit_done) state_d = UART_IDLE;
      end
      default: state_d = UART_IDLE;
    endcase
  end

  // Line level is decoded from the next state so tx_out is aligned with state_q.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      UART_START:  tx_d = 1'b0;
      UART_DATA:   tx_d = shift_d[0];
      UART_PARITY: tx_d = parity_d;
      default:     tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= UART_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

  assign tx_out   = tx_q;
  assign busy     = (state_q != UART_IDLE);
  assign in_ready = (state_q == UART_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: three instances (4 clk/bit no parity, 4 clk/bit with
// parity, 1 clk/bit) checked against a queue of expected frame bit patterns.
module tb_uart_tx;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    logic [7:0]  word;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] valid_r = '0;
  logic [7:0] data_r [3];
  logic [2:0] tx_w, busy_w, ready_w;

  frame_t exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(valid_r[0]), .in_data(data_r[0]),
    .in_ready(ready_w[0]), .tx_out(tx_w[0]), .busy(busy_w[0]));

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(valid_r[1]), .in_data(data_r[1]),
    .in_ready(ready_w[1]), .tx_out(tx_w[1]), .busy(busy_w[1]));

  uart_tx #(.CLKS_PER_BIT(1), .DATA_BITS(8), .PARITY_EN(1'b0)) dut2 (
    .clk(clk), .reset(reset), .in_valid(valid_r[2]), .in_data(data_r[2]),
    .in_ready(ready_w[2]), .tx_out(tx_w[2]), .busy(busy_w[2]));

  // Reference frame: start 0, LSB-first data, optional XOR parity, stop 1.
  function automatic frame_t make_frame(input logic [7:0] w, input bit par);
    frame_t f;
    f.bits    = '0;
    f.word    = w;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1+i] = w[i];
    if (par) begin
      f.bits[9]  = ^w;
      f.bits[10] = 1'b1;
      f.nbits    = 11;
    end else begin
      f.bits[9] = 1'b1;
      f.nbits   = 10;
    end
    return f;
  endfunction

  // Samples one frame starting at the first negedge after the accept edge.
  task automatic capture(input int sel, input int nbits, input int cpb,
                         output logic [15:0] bits, output int unstable,
                         output int busy_cnt, output int ready_cnt);
    bits = '0; unstable = 0; busy_cnt = 0; ready_cnt = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        if (c == 0) bits[b] = tx_w[sel];
        else if (tx_w[sel] !== bits[b]) unstable++;
        if (busy_w[sel] === 1'b1) busy_cnt++;
        if (ready_w[sel] === 1'b1) ready_cnt++;
      end
    end
  endtask

  task automatic drive_word(input int sel, input logic [7:0] w, input bit par);
    @(negedge clk);
    valid_r[sel] = 1'b1;
    data_r[sel]  = w;
    exp_q.push_back(make_frame(w, par));
    @(posedge clk);
    #1 valid_r[sel] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if ({tx_w[d], busy_w[d], ready_w[d]} !== 3'b101) begin
        n_bad++;
        $display("FAIL reset_state dut%0d: tx/busy/ready=%b required 101", d,
                 {tx_w[d], busy_w[d], ready_w[d]});
      end
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if ({tx_w[d], busy_w[d], ready_w[d]} !== 3'b101) begin
        n_bad++;
        $display("FAIL idle_after_reset dut%0d: tx/busy/ready=%b required 101", d,
                 {tx_w[d], busy_w[d], ready_w[d]});
      end
    end
    $display("reset: all instances idle");
  endtask

  task automatic check_frame(input int sel, input int cpb, input string name,
                             input logic [15:0] bits, input int unstable);
    frame_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: frame observed but scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (bits !== e.bits) begin
      n_bad++;
      $display("FAIL %s: bits=%b required %b", name, bits, e.bits);
    end
    n_cmp++;
    if (unstable !== 0) begin
      n_bad++;
      $display("FAIL %s_stable: %0d mid-bit changes required 0", name, unstable);
    end
    $display("frame dut%0d word=0x%02h bits=%b (%0d clk/bit)", sel, e.word, bits, cpb);
  endtask

  task automatic test_basic();
    logic [15:0] bits; int uns, bc, rc;
    drive_word(0, 8'hA5, 1'b0);
    capture(0, 10, 4, bits, uns, bc, rc);
    check_frame(0, 4, "basic_a5", bits, uns);
    n_cmp++;
    if (bc !== 40) begin n_bad++; $display("FAIL basic_busy: busy cycles=%0d required 40", bc); end
    n_cmp++;
    if (rc !== 0) begin n_bad++; $display("FAIL basic_ready_low: ready cycles=%0d required 0", rc); end
    @(negedge clk);
    n_cmp++;
    if ({tx_w[0], busy_w[0], ready_w[0]} !== 3'b101) begin
      n_bad++;
      $display("FAIL basic_cycle41: tx/busy/ready=%b required 101", {tx_w[0], busy_w[0], ready_w[0]});
    end
  endtask

  task automatic test_parity();
    logic [15:0] bits; int uns, bc, rc;
    drive_word(1, 8'h07, 1'b1);
    capture(1, 11, 4, bits, uns, bc, rc);
    check_frame(1, 4, "parity_07", bits, uns);
    n_cmp++;
    if (bc !== 44) begin n_bad++; $display("FAIL parity_busy: busy cycles=%0d required 44", bc); end
    @(negedge clk);
    n_cmp++;
    if (ready_w[1] !== 1'b1) begin n_bad++; $display("FAIL parity_ready: ready=%b required 1", ready_w[1]); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits; int uns, bc, rc;
    @(negedge clk);
    valid_r[0] = 1'b1;
    data_r[0]  = 8'h00;
    exp_q.push_back(make_frame(8'h00, 1'b0));
    exp_q.push_back(make_frame(8'hFF, 1'b0));
    @(posedge clk);
    #1 data_r[0] = 8'hFF;
    capture(0, 10, 4, bits, uns, bc, rc);
    check_frame(0, 4, "b2b_00", bits, uns);
    @(negedge clk);
    n_cmp++;
    if ({tx_w[0], ready_w[0]} !== 2'b11) begin
      n_bad++;
      $display("FAIL b2b_gap: tx/ready=%b required 11", {tx_w[0], ready_w[0]});
    end
    @(posedge clk);
    #1 valid_r[0] = 1'b0;
    capture(0, 10, 4, bits, uns, bc, rc);
    check_frame(0, 4, "b2b_ff", bits, uns);
    n_cmp++;
    if (bc !== 40) begin n_bad++; $display("FAIL b2b_busy: busy cycles=%0d required 40", bc); end
    @(negedge clk);
  endtask

  task automatic test_hold_data();
    logic [15:0] bits; int uns, bc, rc, lows, busys;
    drive_word(0, 8'h3C, 1'b0);
    fork
      capture(0, 10, 4, bits, uns, bc, rc);
      begin
        repeat (2) @(negedge clk);
        data_r[0] = 8'hFF;
        repeat (8) @(negedge clk);
        valid_r[0] = 1'b1;
        @(negedge clk);
        valid_r[0] = 1'b0;
      end
    join
    check_frame(0, 4, "hold_3c", bits, uns);
    lows = 0; busys = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1) lows++;
      if (busy_w[0] !== 1'b0) busys++;
    end
    n_cmp++;
    if (lows !== 0) begin n_bad++; $display("FAIL hold_no_second_tx: low cycles=%0d required 0", lows); end
    n_cmp++;
    if (busys !== 0) begin n_bad++; $display("FAIL hold_no_second_busy: busy cycles=%0d required 0", busys); end
  endtask

  task automatic test_reset_mid();
    frame_t dropped;
    int lows, busys;
    drive_word(0, 8'h55, 1'b0);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({tx_w[0], busy_w[0], ready_w[0]} !== 3'b101) begin
      n_bad++;
      $display("FAIL reset_mid: tx/busy/ready=%b required 101", {tx_w[0], busy_w[0], ready_w[0]});
    end
    reset = 1'b0;
    dropped = exp_q.pop_front();
    $display("abort dut0 word=0x%02h discarded by reset", dropped.word);
    lows = 0; busys = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1) lows++;
      if (busy_w[0] !== 1'b0) busys++;
    end
    n_cmp++;
    if (lows !== 0) begin n_bad++; $display("FAIL reset_mid_no_retx: low cycles=%0d required 0", lows); end
    n_cmp++;
    if (busys !== 0) begin n_bad++; $display("FAIL reset_mid_idle: busy cycles=%0d required 0", busys); end
  endtask

  task automatic test_cpb1();
    logic [15:0] bits; int uns, bc, rc;
    drive_word(2, 8'h81, 1'b0);
    capture(2, 10, 1, bits, uns, bc, rc);
    check_frame(2, 1, "cpb1_81", bits, uns);
    n_cmp++;
    if (bc !== 10) begin n_bad++; $display("FAIL cpb1_busy: busy cycles=%0d required 10", bc); end
    @(negedge clk);
    n_cmp++;
    if ({tx_w[2], ready_w[2]} !== 2'b11) begin
      n_bad++;
      $display("FAIL cpb1_idle: tx/ready=%b required 11", {tx_w[2], ready_w[2]});
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) data_r[d] = 8'h00;
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_hold_data();
    test_reset_mid();
    test_cpb1();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL scoreboard_drained: %0d frames left required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
